// File: rtl/uart_pkg.sv
// Shared definitions for the UART command framer.
// Contents: frame FSM state encoding, err_code values, default frame start marker.
package uart_pkg;

   typedef enum logic [2:0] {
      HUNT  = 3'd0,
      ADDR  = 3'd1,
      LEN   = 3'd2,
      DATA  = 3'd3,
      CSUM  = 3'd4,
      DRAIN = 3'd5
   } frame_state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_CSUM    = 3'd1;
   localparam logic [2:0] ERR_LEN     = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_OVERRUN = 3'd4;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for one frame: MAX_LEN x 8 storage, write pointer, read pointer.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (pointers only)
//   clr          frame start: both pointers return to 0
//   wr_en        store wr_byte at the write pointer and advance it
//   wr_byte      payload byte to store
//   rd_adv       advance the read pointer (current entry consumed)
//   rd_byte      entry at the read pointer
module uart_frame_buf #(
   parameter int MAX_LEN = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       wr_en,
   input  logic [7:0] wr_byte,
   input  logic       rd_adv,
   output logic [7:0] rd_byte
);
   import uart_pkg::*;

   localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [7:0]    mem [MAX_LEN];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en)  wptr <= wptr + PW'(1);
         if (rd_adv) rptr <= rptr + PW'(1);
      end
   end

   // Storage carries data only, so it is never reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= wr_byte;
   end

   assign rd_byte = mem[rptr];

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Frames the UART receive byte stream (SYNC, ADDR, LEN, payload, CSUM) into
// register write commands, verifies the checksum and drains the buffered
// payload over a valid/ready write port. Reports and counts framing errors.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_data, rx_finish  received byte and its one-cycle strobe
//   wr_valid, wr_ready  write command handshake
//   wr_addr, wr_data    write command (addr increments per payload byte)
//   frame_ok            one-cycle pulse: frame passed its checksum
//   frame_err           one-cycle pulse: frame discarded or byte dropped
//   err_code            cause of the last frame_err (held)
//   err_cnt             saturating error total
module uart_rx_cmd_ctrl
   import uart_pkg::*;
#(
   parameter int         MAX_LEN      = 16,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CLKS = 43400
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_finish,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [2:0] err_code,
   output logic [7:0] err_cnt
);

   localparam int         LW        = $clog2(MAX_LEN + 1);
   localparam int         TW        = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   frame_state_t  state, state_nxt;
   logic [7:0]    addr, addr_nxt;
   logic [7:0]    sum, sum_nxt;
   logic [LW-1:0] len, len_nxt;
   logic [LW-1:0] cnt, cnt_nxt;
   logic [LW-1:0] cnt_inc;
   logic [TW-1:0] tmo_cnt;
   logic          in_frame;
   logic          tmo_exp;
   logic          ok_set;
   logic          err_set;
   logic [2:0]    code_set;
   logic          buf_clr;
   logic          buf_we;
   logic          buf_rd;
   logic [7:0]    buf_byte;

   uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (buf_clr),
      .wr_en   (buf_we),
      .wr_byte (rx_data),
      .rd_adv  (buf_rd),
      .rd_byte (buf_byte)
   );

   assign cnt_inc  = cnt + LW'(1);
   assign in_frame = (state == ADDR) || (state == LEN) ||
                     (state == DATA) || (state == CSUM);
   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign tmo_exp  = in_frame && !rx_finish &&
                     (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      sum_nxt   = sum;
      len_nxt   = len;
      cnt_nxt   = cnt;
      ok_set    = 1'b0;
      err_set   = 1'b0;
      code_set  = err_code;
      buf_clr   = 1'b0;
      buf_we    = 1'b0;
      buf_rd    = 1'b0;
      wr_valid  = 1'b0;

      unique case (state)
         HUNT: begin
            if (rx_finish && rx_data == SYNC_BYTE) begin
               state_nxt = ADDR;
               cnt_nxt   = '0;
               buf_clr   = 1'b1;
            end
         end
         ADDR: begin
            if (rx_finish) begin
               addr_nxt  = rx_data;
               sum_nxt   = rx_data;
               state_nxt = LEN;
            end
         end
         LEN: begin
            if (rx_finish) begin
               if (rx_data > MAX_LEN_B) begin
                  err_set   = 1'b1;
                  code_set  = ERR_LEN;
                  state_nxt = HUNT;
               end else begin
                  len_nxt   = LW'(rx_data);
                  sum_nxt   = sum + rx_data;
                  state_nxt = (rx_data == 8'd0) ? CSUM : DATA;
               end
            end
         end
         DATA: begin
            if (rx_finish) begin
               buf_we  = 1'b1;
               sum_nxt = sum + rx_data;
               cnt_nxt = cnt_inc;
               if (cnt_inc == len) state_nxt = CSUM;
            end
         end
         CSUM: begin
            if (rx_finish) begin
               if (8'(sum + rx_data) == 8'd0) begin
                  ok_set    = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = (len == '0) ? HUNT : DRAIN;
               end else begin
                  err_set   = 1'b1;
                  code_set  = ERR_CSUM;
                  state_nxt = HUNT;
               end
            end
         end
         DRAIN: begin
            wr_valid = 1'b1;
            if (wr_ready) begin
               buf_rd  = 1'b1;
               cnt_nxt = cnt_inc;
               if (cnt_inc == len) state_nxt = HUNT;
            end
            // The receiver cannot be stalled, so a byte here is lost.
            if (rx_finish) begin
               err_set  = 1'b1;
               code_set = ERR_OVERRUN;
            end
         end
         default: state_nxt = HUNT;
      endcase

      if (tmo_exp) begin
         err_set   = 1'b1;
         code_set  = ERR_TIMEOUT;
         state_nxt = HUNT;
      end
   end

   // Outputs read zero outside of a drain, including straight after reset.
   assign wr_addr = wr_valid ? 8'(addr + 8'(cnt)) : 8'd0;
   assign wr_data = wr_valid ? buf_byte : 8'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= HUNT;
         len       <= '0;
         cnt       <= '0;
         tmo_cnt   <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= ERR_NONE;
         err_cnt   <= 8'd0;
      end else begin
         state     <= state_nxt;
         len       <= len_nxt;
         cnt       <= cnt_nxt;
         frame_ok  <= ok_set;
         frame_err <= err_set;
         err_code  <= code_set;
         if (!in_frame || rx_finish) tmo_cnt <= '0;
         else                        tmo_cnt <= tmo_cnt + TW'(1);
         if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

   // Address and running checksum are pure data.
   always_ff @(posedge clk) begin
      addr <= addr_nxt;
      sum  <= sum_nxt;
   end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
module tb_uart_rx_cmd_ctrl;

   localparam int TMO = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       rx_finish = 1'b0;
   logic       wr_valid;
   logic       wr_ready = 1'b0;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_ok;
   logic       frame_err;
   logic [2:0] err_code;
   logic [7:0] err_cnt;

   int checks = 0;
   int errors = 0;
   int ok_seen = 0;
   logic [15:0] acc_q [$];

   uart_rx_cmd_ctrl #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_finish (rx_finish),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Record accepted writes and frame_ok pulses as seen at each clock edge.
   always @(posedge clk) begin
      if (wr_valid && wr_ready) acc_q.push_back({wr_addr, wr_data});
      if (frame_ok) ok_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One idle cycle, then a one-cycle strobe; returns just after the byte's edge.
   task automatic send(input logic [7:0] b);
      step();
      rx_data   = b;
      rx_finish = 1'b1;
      step();
      rx_finish = 1'b0;
   endtask

   function automatic logic [15:0] acc_at(input int i);
      if (i < acc_q.size()) return acc_q[i];
      return 16'hDEAD;
   endfunction

   initial begin
      int n;
      int ok0;

      // Reset
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_wr_valid", wr_valid, 0);
      check("rst_frame_ok", frame_ok, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      rst_n = 1'b1;
      step();

      // 1. Good frame
      wr_ready = 1'b1;
      acc_q.delete();
      ok0 = ok_seen;
      send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22);
      check("t1_no_early_ok", frame_ok, 0);
      send(8'hBB);
      check("t1_frame_ok", frame_ok, 1);
      check("t1_wr_valid", wr_valid, 1);
      check("t1_w0", {wr_addr, wr_data}, 16'h1011);
      step();
      check("t1_ok_pulse", frame_ok, 0);
      check("t1_w1", {wr_addr, wr_data}, 16'h1122);
      step();
      check("t1_done", wr_valid, 0);
      repeat (3) step();
      check("t1_nacc", acc_q.size(), 2);
      check("t1_acc0", acc_at(0), 16'h1011);
      check("t1_acc1", acc_at(1), 16'h1122);
      check("t1_ok_cnt", ok_seen - ok0, 1);
      check("t1_err_cnt", err_cnt, 0);

      // 2. Bad checksum
      acc_q.delete();
      send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'hBC);
      check("t2_frame_err", frame_err, 1);
      check("t2_code", err_code, 1);
      check("t2_cnt", err_cnt, 1);
      check("t2_no_valid", wr_valid, 0);
      step();
      check("t2_err_pulse", frame_err, 0);
      check("t2_code_held", err_code, 1);
      repeat (3) step();
      check("t2_nacc", acc_q.size(), 0);

      // 3. Backpressure
      wr_ready = 1'b0;
      acc_q.delete();
      send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'hBB);
      check("t3_ok", frame_ok, 1);
      for (int i = 0; i < 5; i++) begin
         check("t3_stall0_valid", wr_valid, 1);
         check("t3_stall0_w", {wr_addr, wr_data}, 16'h1011);
         step();
      end
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t3_stall1_valid", wr_valid, 1);
         check("t3_stall1_w", {wr_addr, wr_data}, 16'h1122);
         step();
      end
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      check("t3_done", wr_valid, 0);
      check("t3_nacc", acc_q.size(), 2);
      check("t3_acc0", acc_at(0), 16'h1011);
      check("t3_acc1", acc_at(1), 16'h1122);

      // 4a. Length error
      send(8'hA5); send(8'h00); send(8'h11);
      check("t4_len_err", frame_err, 1);
      check("t4_len_code", err_code, 2);
      check("t4_len_cnt", err_cnt, 2);

      // 4b. Timeout
      send(8'hA5); send(8'h10);
      n = 0;
      while (!frame_err && n < 3 * TMO) begin
         step();
         n++;
      end
      check("t4_tmo_err", frame_err, 1);
      check("t4_tmo_lat_ok", (n >= TMO - 1 && n <= TMO + 1), 1);
      check("t4_tmo_code", err_code, 3);
      check("t4_tmo_cnt", err_cnt, 3);

      // 4c. Next good frame, bytes spaced below the timeout
      wr_ready = 1'b1;
      acc_q.delete();
      send(8'hA5);
      repeat (TMO - 20) step();
      send(8'h10);
      repeat (TMO - 20) step();
      send(8'h02); send(8'h11); send(8'h22); send(8'hBB);
      check("t4_good_ok", frame_ok, 1);
      repeat (4) step();
      check("t4_good_nacc", acc_q.size(), 2);
      check("t4_good_acc1", acc_at(1), 16'h1122);
      check("t4_good_cnt", err_cnt, 3);

      // 5a. Zero-length frame
      acc_q.delete();
      send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
      check("t5_zero_ok", frame_ok, 1);
      check("t5_zero_novalid", wr_valid, 0);
      repeat (3) step();
      check("t5_zero_nacc", acc_q.size(), 0);

      // 5b. Address wrap
      send(8'hA5); send(8'hFF); send(8'h02); send(8'h01); send(8'h02); send(8'hFC);
      check("t5_wrap_ok", frame_ok, 1);
      repeat (4) step();
      check("t5_wrap_nacc", acc_q.size(), 2);
      check("t5_wrap_acc0", acc_at(0), 16'hFF01);
      check("t5_wrap_acc1", acc_at(1), 16'h0002);

      // 6a. Overrun during stalled drain
      wr_ready = 1'b0;
      acc_q.delete();
      send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'hBB);
      send(8'hA5);
      check("t6_ovr_err", frame_err, 1);
      check("t6_ovr_code", err_code, 4);
      check("t6_ovr_cnt", err_cnt, 4);
      check("t6_ovr_valid", wr_valid, 1);
      check("t6_ovr_w", {wr_addr, wr_data}, 16'h1011);
      wr_ready = 1'b1;
      repeat (4) step();
      check("t6_ovr_nacc", acc_q.size(), 2);
      check("t6_ovr_acc1", acc_at(1), 16'h1122);
      check("t6_ovr_done", wr_valid, 0);

      // 6b. Reset mid-DATA
      acc_q.delete();
      send(8'hA5); send(8'h20); send(8'h03); send(8'h01);
      rst_n = 1'b0;
      step();
      check("t6_rst_valid", wr_valid, 0);
      check("t6_rst_code", err_code, 0);
      check("t6_rst_cnt", err_cnt, 0);
      check("t6_rst_err", frame_err, 0);
      rst_n = 1'b1;
      ok0 = ok_seen;
      send(8'h02);
      send(8'hA5); send(8'h30); send(8'h01); send(8'h55); send(8'h7A);
      check("t6_post_ok", frame_ok, 1);
      check("t6_post_w", {wr_addr, wr_data}, 16'h3055);
      repeat (3) step();
      check("t6_post_nacc", acc_q.size(), 1);
      check("t6_post_acc0", acc_at(0), 16'h3055);
      check("t6_post_okcnt", ok_seen - ok0, 1);
      check("t6_post_errcnt", err_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
